// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO bus controller: FSM encoding,
// region-select default, timeout read value and counter width.
package mio_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RAM_ACC = 2'd1,
      PER_ACC = 2'd2,
      DONE    = 2'd3
   } mio_state_t;

   // Default value of addr[31:28] that selects the peripheral region
   localparam logic [3:0]  PERIPH_BASE_DEF = 4'hE;

   // Read value returned when a peripheral access times out
   localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

   // Width of the shared wait-state counter
   localparam int CNT_W = 8;

   // True when the byte address falls in the peripheral region
   function automatic logic is_periph(input logic [31:0] a, input logic [3:0] base);
      return (a[31:28] == base);
   endfunction

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU-side request/response bundle between the control unit (master)
// and the memory/IO bus controller (slave).
interface mio_bus_ctrl_if;

   logic        MemRead;
   logic        MemWrite;
   logic        CPU_MIO;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        MIO_ready;
   logic        bus_err;

   modport master (
      output MemRead, MemWrite, CPU_MIO, addr, wdata,
      input  rdata, MIO_ready, bus_err
   );

   modport slave (
      input  MemRead, MemWrite, CPU_MIO, addr, wdata,
      output rdata, MIO_ready, bus_err
   );

endinterface

// File: rtl/mio_wait_cnt.sv
// Wait-state counter shared by the RAM and peripheral access phases.
// Clear has priority over enable; hit flags that the count equals term.
module mio_wait_cnt
   import mio_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic             hit
);

   logic [CNT_W-1:0] count_r;

   // Up-count while enabled, restart from zero on clear or reset
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= 8'd0;
      end else if (clr) begin
         count_r <= 8'd0;
      end else if (en) begin
         count_r <= count_r + 8'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign hit = (count_r == term);

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: accepts a CPU access, routes it to block RAM
// or the peripheral bus by address region, inserts wait states and
// returns read data with a single-cycle MIO_ready (and bus_err on timeout).
module mio_bus_ctrl
   import mio_pkg::*;
#(
   parameter int         RAM_WAIT    = 1,
   parameter int         RAM_AW      = 10,
   parameter int         TIMEOUT     = 16,
   parameter logic [3:0] PERIPH_BASE = PERIPH_BASE_DEF
)(
   input  logic              clk,
   input  logic              reset,
   mio_bus_ctrl_if.slave     cpu,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,
   output logic              per_req,
   output logic              per_we,
   output logic [31:0]       per_addr,
   output logic [31:0]       per_wdata,
   input  logic              per_ack,
   input  logic [31:0]       per_rdata
);

   // Terminal counts: last RAM wait cycle and last cycle before giving up
   localparam logic [CNT_W-1:0] RAM_TERM = CNT_W'(RAM_WAIT - 1);
   localparam logic [CNT_W-1:0] PER_TERM = CNT_W'(TIMEOUT - 1);

   mio_state_t       state_r;
   logic             write_r;
   logic [31:0]      rdata_r;
   logic             ready_r;
   logic             err_r;

   logic             req_s;
   logic             cnt_clr_s;
   logic             cnt_en_s;
   logic [CNT_W-1:0] cnt_term_s;
   logic             cnt_hit_s;

   assign req_s = cpu.CPU_MIO & (cpu.MemRead | cpu.MemWrite);

   // Counter control: cleared while waiting for a request, running during access
   always_comb begin
      cnt_clr_s  = 1'b1;
      cnt_en_s   = 1'b0;
      cnt_term_s = RAM_TERM;
      case (state_r)
         RAM_ACC: begin
            cnt_clr_s  = 1'b0;
            cnt_en_s   = 1'b1;
            cnt_term_s = RAM_TERM;
         end
         PER_ACC: begin
            cnt_clr_s  = 1'b0;
            cnt_en_s   = 1'b1;
            cnt_term_s = PER_TERM;
         end
         default: begin
            cnt_clr_s  = 1'b1;
            cnt_en_s   = 1'b0;
            cnt_term_s = RAM_TERM;
         end
      endcase
   end

   mio_wait_cnt u_wait_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr_s),
      .en    (cnt_en_s),
      .term  (cnt_term_s),
      .hit   (cnt_hit_s)
   );

   // Access sequencer; every bus-facing output is registered here
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         write_r   <= 1'b0;
         rdata_r   <= 32'h0000_0000;
         ready_r   <= 1'b0;
         err_r     <= 1'b0;
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_din   <= 32'h0000_0000;
         per_req   <= 1'b0;
         per_we    <= 1'b0;
         per_addr  <= 32'h0000_0000;
         per_wdata <= 32'h0000_0000;
      end else begin
         // Single-cycle strobes fall back low unless re-armed below
         ram_we  <= 1'b0;
         ready_r <= 1'b0;
         err_r   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req_s) begin
                  // A simultaneous read+write request is treated as a write
                  write_r <= cpu.MemWrite;
                  if (is_periph(cpu.addr, PERIPH_BASE)) begin
                     state_r   <= PER_ACC;
                     per_req   <= 1'b1;
                     per_we    <= cpu.MemWrite;
                     per_addr  <= cpu.addr;
                     per_wdata <= cpu.wdata;
                  end else begin
                     state_r   <= RAM_ACC;
                     ram_we    <= cpu.MemWrite;
                     ram_addr  <= cpu.addr[RAM_AW+1:2];
                     ram_din   <= cpu.wdata;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RAM_ACC: begin
               if (cnt_hit_s) begin
                  if (!write_r) begin
                     rdata_r <= ram_dout;
                  end else begin
                     rdata_r <= rdata_r;
                  end
                  ready_r <= 1'b1;
                  state_r <= DONE;
               end else begin
                  state_r <= RAM_ACC;
               end
            end
            PER_ACC: begin
               // Ack is checked first so a last-cycle ack is not an error
               if (per_ack) begin
                  if (!write_r) begin
                     rdata_r <= per_rdata;
                  end else begin
                     rdata_r <= rdata_r;
                  end
                  per_req <= 1'b0;
                  per_we  <= 1'b0;
                  ready_r <= 1'b1;
                  state_r <= DONE;
               end else if (cnt_hit_s) begin
                  rdata_r <= ERR_RDATA;
                  err_r   <= 1'b1;
                  per_req <= 1'b0;
                  per_we  <= 1'b0;
                  ready_r <= 1'b1;
                  state_r <= DONE;
               end else begin
                  state_r <= PER_ACC;
               end
            end
            DONE: begin
               // Requests seen here are ignored; one idle cycle before next accept
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign cpu.rdata     = rdata_r;
   assign cpu.MIO_ready = ready_r;
   assign cpu.bus_err   = err_r;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl. Two instances (RAM_WAIT=1 and 3) see the
// same CPU/RAM/peripheral stimulus; expected completions are queued per
// instance when a request is issued and matched when MIO_ready fires.
module tb_mio_bus_ctrl
   import mio_pkg::*;
;

   localparam int TO = 16;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic        cpu_mio = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] ram_dout = 32'h0;
   logic        per_ack = 1'b0;
   logic [31:0] per_rdata = 32'h0;

   logic [9:0]  ram_addr1, ram_addr3;
   logic        ram_we1, ram_we3;
   logic [31:0] ram_din1, ram_din3;
   logic        per_req1, per_req3;
   logic        per_we1, per_we3;
   logic [31:0] per_addr1, per_addr3;
   logic [31:0] per_wdata1, per_wdata3;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] last_rd = 32'h0;
   exp_t        q1[$];
   exp_t        q3[$];
   exp_t        e1, e3;
   logic        rdy1, rdy3;

   mio_bus_ctrl_if if1();
   mio_bus_ctrl_if if3();

   assign if1.MemRead  = mem_read;
   assign if1.MemWrite = mem_write;
   assign if1.CPU_MIO  = cpu_mio;
   assign if1.addr     = addr;
   assign if1.wdata    = wdata;
   assign if3.MemRead  = mem_read;
   assign if3.MemWrite = mem_write;
   assign if3.CPU_MIO  = cpu_mio;
   assign if3.addr     = addr;
   assign if3.wdata    = wdata;

   mio_bus_ctrl #(.RAM_WAIT(1), .RAM_AW(10), .TIMEOUT(TO), .PERIPH_BASE(4'hE)) u_d1 (
      .clk(clk), .reset(reset), .cpu(if1),
      .ram_addr(ram_addr1), .ram_we(ram_we1), .ram_din(ram_din1), .ram_dout(ram_dout),
      .per_req(per_req1), .per_we(per_we1), .per_addr(per_addr1), .per_wdata(per_wdata1),
      .per_ack(per_ack), .per_rdata(per_rdata)
   );

   mio_bus_ctrl #(.RAM_WAIT(3), .RAM_AW(10), .TIMEOUT(TO), .PERIPH_BASE(4'hE)) u_d3 (
      .clk(clk), .reset(reset), .cpu(if3),
      .ram_addr(ram_addr3), .ram_we(ram_we3), .ram_din(ram_din3), .ram_dout(ram_dout),
      .per_req(per_req3), .per_we(per_we3), .per_addr(per_addr3), .per_wdata(per_wdata3),
      .per_ack(per_ack), .per_rdata(per_rdata)
   );

   always #5 clk = ~clk;

   // Cycle index: value seen during the cycle that follows edge number cyc
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard for the RAM_WAIT=1 instance
   always @(negedge clk) begin
      if (!reset) begin
         rdy1 = (q1.size() > 0) && (q1[0].cyc == cyc);
         check("d1_mio_ready", 32'(if1.MIO_ready), 32'(rdy1));
         if (rdy1) begin
            e1 = q1.pop_front();
            check("d1_rdata", if1.rdata, e1.rdata);
            check("d1_bus_err", 32'(if1.bus_err), 32'(e1.err));
         end else begin
            check("d1_bus_err_quiet", 32'(if1.bus_err), 32'd0);
         end
      end
   end

   // Scoreboard for the RAM_WAIT=3 instance
   always @(negedge clk) begin
      if (!reset) begin
         rdy3 = (q3.size() > 0) && (q3[0].cyc == cyc);
         check("d3_mio_ready", 32'(if3.MIO_ready), 32'(rdy3));
         if (rdy3) begin
            e3 = q3.pop_front();
            check("d3_rdata", if3.rdata, e3.rdata);
            check("d3_bus_err", 32'(if3.bus_err), 32'(e3.err));
         end else begin
            check("d3_bus_err_quiet", 32'(if3.bus_err), 32'd0);
         end
      end
   end

   // One CPU access; request is held for the accept cycle only, then dropped.
   // ack_at = PER_ACC cycle (1-based) in which per_ack is high, 0 = never.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int ack_at,
                            input logic [31:0] dev_data, input logic exp_err);
      int          c;
      logic        is_per;
      logic [31:0] exp_rd;
      exp_t        e;
      is_per = (a[31:28] == 4'hE);
      exp_rd = exp_err ? 32'h0 : (wr ? last_rd : dev_data);
      last_rd = exp_rd;
      @(negedge clk);
      if (is_per) per_rdata = dev_data;
      else        ram_dout  = dev_data;
      mem_read = rd; mem_write = wr; cpu_mio = 1'b1; addr = a; wdata = wd;
      c = cyc;
      e.rdata = exp_rd;
      e.err   = exp_err;
      if (is_per) begin
         e.cyc = c + ((ack_at > 0) ? ack_at + 1 : TO + 1);
         q1.push_back(e);
         q3.push_back(e);
      end else begin
         e.cyc = c + 2;
         q1.push_back(e);
         e.cyc = c + 4;
         q3.push_back(e);
      end
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         cpu_mio = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
         per_ack = is_per && (i == ack_at);
         if (i == 1 && !is_per) begin
            check("ram_addr1", 32'(ram_addr1), 32'(a[11:2]));
            check("ram_addr3", 32'(ram_addr3), 32'(a[11:2]));
            check("ram_we1_first", 32'(ram_we1), 32'(wr));
            check("ram_we3_first", 32'(ram_we3), 32'(wr));
            check("ram_din3", ram_din3, wd);
            check("per_req1_ram", 32'(per_req1), 32'd0);
         end
         if (i == 2 && !is_per) begin
            check("ram_we1_second", 32'(ram_we1), 32'd0);
            check("ram_we3_second", 32'(ram_we3), 32'd0);
         end
         if (i == 1 && is_per) begin
            check("per_req1", 32'(per_req1), 32'd1);
            check("per_req3", 32'(per_req3), 32'd1);
            check("per_we1", 32'(per_we1), 32'(wr));
            check("per_addr1", per_addr1, a);
            check("per_wdata3", per_wdata3, wd);
            check("ram_we1_per", 32'(ram_we1), 32'd0);
         end
         #1;
         if (q1.size() == 0 && q3.size() == 0) break;
      end
      per_ack = 1'b0;
      check("access_completed", 32'(q1.size() + q3.size()), 32'd0);
      if (is_per) begin
         check("per_req1_after", 32'(per_req1), 32'd0);
         check("per_req3_after", 32'(per_req3), 32'd0);
      end
   endtask

   // Reset state of every registered output plus the FSM
   task automatic check_reset_state(input string pfx);
      check({pfx, "_state1"}, 32'(u_d1.state_r), 32'(IDLE));
      check({pfx, "_state3"}, 32'(u_d3.state_r), 32'(IDLE));
      check({pfx, "_rdata1"}, if1.rdata, 32'h0);
      check({pfx, "_rdata3"}, if3.rdata, 32'h0);
      check({pfx, "_ready1"}, 32'(if1.MIO_ready), 32'd0);
      check({pfx, "_err3"}, 32'(if3.bus_err), 32'd0);
      check({pfx, "_ram_we1"}, 32'(ram_we1), 32'd0);
      check({pfx, "_ram_we3"}, 32'(ram_we3), 32'd0);
      check({pfx, "_per_req1"}, 32'(per_req1), 32'd0);
      check({pfx, "_per_we3"}, 32'(per_we3), 32'd0);
      check({pfx, "_ram_addr3"}, 32'(ram_addr3), 32'd0);
      check({pfx, "_ram_din3"}, ram_din3, 32'h0);
      check({pfx, "_per_addr1"}, per_addr1, 32'h0);
      check({pfx, "_per_wdata1"}, per_wdata1, 32'h0);
   endtask

   initial begin
      // Power-on reset
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_state("por");
      reset = 1'b0;
      @(negedge clk);

      // RAM read: ram_addr = 4, data returned on completion
      do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678, 1'b0);

      // RAM write: ram_we single cycle, rdata keeps the previous read
      do_access(1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_0001, 0, 32'h5555_AAAA, 1'b0);

      // Peripheral read, ack in the 3rd PER_ACC cycle, request dropped after accept
      do_access(1'b1, 1'b0, 32'hE000_0004, 32'h0, 3, 32'hA5A5_0F0F, 1'b0);

      // Peripheral timeout: no ack at all
      do_access(1'b1, 1'b0, 32'hE000_0008, 32'h0, 0, 32'h7777_7777, 1'b1);

      // Ack coincides with the timeout cycle: ack wins, no error
      do_access(1'b1, 1'b0, 32'hE000_000C, 32'h0, TO, 32'h0BAD_F00D, 1'b0);

      // Peripheral write: rdata unchanged
      do_access(1'b0, 1'b1, 32'hE000_0020, 32'h1357_9BDF, 2, 32'hFFFF_0000, 1'b0);

      // MemRead and MemWrite together behave as a write
      do_access(1'b1, 1'b1, 32'h0000_0080, 32'h1111_2222, 0, 32'hFFFF_FFFF, 1'b0);

      // Reset one cycle into a RAM write
      @(negedge clk);
      mem_write = 1'b1; cpu_mio = 1'b1; addr = 32'h0000_0100; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_write = 1'b0; cpu_mio = 1'b0;
      check("pre_reset_ram_we3", 32'(ram_we3), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_reset_state("mid");
      reset = 1'b0;
      last_rd = 32'h0;
      @(negedge clk);
      check("post_reset_idle_ready3", 32'(if3.MIO_ready), 32'd0);

      // Normal operation resumes after the mid-access reset
      do_access(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 0, 32'h8642_0ACE, 1'b0);

      repeat (3) @(negedge clk);
      check("no_pending1", 32'(q1.size()), 32'd0);
      check("no_pending3", 32'(q3.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard stop if the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: observed=stalled expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
